// File: rtl/dmem_responder_if.sv
// Core-side data-memory port: the store strobe, address and store data
// driven by the memory stage, and the combinational load data returned.
interface dmem_responder_if;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output memwrite, output addr, output writedata, input readdata);
  modport slave  (input memwrite, input addr, input writedata, output readdata);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS memory stage.
// - Word-addressed RAM; upper address bits alias onto it.
// - 32-byte I/O window at IO_BASE holding CYCLE, LOAD, COUNT, CTRL and GPIO.
// - Loads are combinational. Stores commit on the rising clock edge.
// - The down-counting timer (LOAD/COUNT/CTRL, timer_irq) exists only when
//   DMEM_TIMER_EN is defined. Without it, those offsets read 0 and
//   timer_irq is tied low.
module dmem_responder #(
  parameter int          DEPTH_LOG2 = 6,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output logic [31:0]       gpio_out,
  output logic              timer_irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [2:0] OFF_CYCLE = 3'd0;
  localparam logic [2:0] OFF_LOAD  = 3'd1;
  localparam logic [2:0] OFF_COUNT = 3'd2;
  localparam logic [2:0] OFF_CTRL  = 3'd3;
  localparam logic [2:0] OFF_GPIO  = 3'd4;

  logic [31:0]           ram [DEPTH];
  logic                  io_sel;
  logic [2:0]            io_off;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  we;
  logic                  ram_we;
  logic [31:0]           rdata;
  logic [31:0]           cycle_q, cycle_d;
  logic [31:0]           gpio_q, gpio_d;
  logic                  unused_addr_lsb;

  assign io_sel          = (bus.addr[31:5] == IO_BASE[31:5]);
  assign io_off          = bus.addr[4:2];
  assign ram_idx         = bus.addr[DEPTH_LOG2+1:2];
  // A store seen while reset is held must not land anywhere, RAM included.
  assign we              = bus.memwrite & ~reset;
  assign ram_we          = we & ~io_sel;
  assign unused_addr_lsb = ^bus.addr[1:0];

  // RAM commits on the edge; it is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= bus.writedata;
  end

  // Next state for the free-running cycle counter and the GPIO register.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    gpio_d  = gpio_q;
    if (we && io_sel && io_off == OFF_GPIO) gpio_d = bus.writedata;
  end

  // Cycle counter and GPIO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
      gpio_q  <= '0;
    end else begin
      cycle_q <= cycle_d;
      gpio_q  <= gpio_d;
    end
  end

  assign gpio_out = gpio_q;

`ifdef DMEM_TIMER_EN
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        exp_q, exp_d;
  logic        ie_q, ie_d;
  logic        tick;
  logic        expire;
  logic        wr_load;
  logic        wr_ctrl;
  logic [31:0] ctrl_rd;

  assign wr_load = we && io_sel && (io_off == OFF_LOAD);
  assign wr_ctrl = we && io_sel && (io_off == OFF_CTRL);
  assign tick    = en_q && (count_q != 32'd0);
  assign expire  = tick && (count_q == 32'd1);

  // Timer step first, then register writes override it, so a written
  // LOAD or EN wins over the timer's own update. EXP set beats W1C.
  always_comb begin
    load_d  = load_q;
    count_d = count_q;
    en_d    = en_q;
    auto_d  = auto_q;
    ie_d    = ie_q;
    if (tick) begin
      if (expire) begin
        if (auto_q) begin
          count_d = load_q;
        end else begin
          count_d = 32'd0;
          en_d    = 1'b0;
        end
      end else begin
        count_d = count_q - 32'd1;
      end
    end
    exp_d = (exp_q & ~(wr_ctrl & bus.writedata[2])) | expire;
    if (wr_load) begin
      load_d  = bus.writedata;
      count_d = bus.writedata;
    end
    if (wr_ctrl) begin
      en_d   = bus.writedata[0];
      auto_d = bus.writedata[1];
      ie_d   = bus.writedata[3];
    end
  end

  // Timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q  <= '0;
      count_q <= '0;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      exp_q   <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      load_q  <= load_d;
      count_q <= count_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      exp_q   <= exp_d;
      ie_q    <= ie_d;
    end
  end

  assign ctrl_rd   = {28'd0, ie_q, exp_q, auto_q, en_q};
  assign timer_irq = exp_q & ie_q;
`else
  assign timer_irq = 1'b0;
`endif

  // Load data mux; reads see pre-edge state, so a same-cycle store is not visible.
  always_comb begin
    rdata = '0;
    if (io_sel) begin
      case (io_off)
        OFF_CYCLE: rdata = cycle_q;
`ifdef DMEM_TIMER_EN
        OFF_LOAD:  rdata = load_q;
        OFF_COUNT: rdata = count_q;
        OFF_CTRL:  rdata = ctrl_rd;
`endif
        OFF_GPIO:  rdata = gpio_q;
        default:   rdata = '0;
      endcase
    end else begin
      rdata = ram[ram_idx];
    end
  end

  assign bus.readdata = rdata;

endmodule
